// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC core: memory command encodings and
// the fetch state type, which the control FSM also uses for debug visibility.
package cpu_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DROP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer holding {pc, instruction} entries. Flush is
// synchronous and wins over push/pop; the head output reads zero when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           valid,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign valid   = (count != '0);
  assign rd_data = valid ? storage[rd_ptr] : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) storage[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Free-running instruction fetcher with one outstanding read, feeding a
// PC-tagged prefetch queue; supports wait states, redirect with flush, and halt.
module fetch_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_take,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e              state, state_next;
  logic [ADDR_W-1:0]         fetch_pc_next;
  logic [ADDR_W-1:0]         req_addr;
  logic [CW-1:0]             count;
  logic [CW-1:0]             post_count;
  logic                      push;
  logic                      pop;
  logic                      flush;
  logic                      room;
  logic [ADDR_W+DATA_W-1:0]  head;

  assign pop        = ir_take && ir_valid && !redirect;
  assign room       = count < CW'(DEPTH);
  assign post_count = count + CW'(1) - CW'(pop);

  // A request stays on the bus in DROP too: reads are never retracted.
  assign mem_cmd  = (state == REQ || state == DROP) ? MREAD : MNONE;
  assign mem_addr = req_addr;

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    flush         = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && room && !halt) state_next = REQ;
      end
      REQ: begin
        if (redirect) begin
          state_next = mem_ready ? IDLE : DROP;
        end else if (mem_ready) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + ADDR_W'(1);
          state_next    = (post_count < CW'(DEPTH) && !halt) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) begin
      flush         = 1'b1;
      fetch_pc_next = redirect_pc;
    end
  end

  // req_addr only follows fetch_pc on entry to (or continuation of) REQ,
  // so DROP keeps presenting the abandoned address until it completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (state_next == REQ) req_addr <= fetch_pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .wr_data ({fetch_pc, mem_rdata}),
    .pop     (pop),
    .rd_data (head),
    .valid   (ir_valid),
    .count   (count)
  );

  assign ir_pc   = head[DATA_W +: ADDR_W];
  assign ir_data = head[DATA_W-1:0];

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction-fetch front end for the 16-bit RISC machine. It replaces the fixed IF1/IF2/updatePC sequence with a free-running fetcher that holds at most one outstanding read. Fetched words go into a DEPTH-entry prefetch queue, each tagged with its PC. It sits between the memory port (`mem_cmd`/`mem_addr`) and the decode/control FSM, and supports memory wait states, branch redirect with flush, and halt.

## Interface
- `ADDR_W`, 9: PC / memory address width.
- `DATA_W`, 16: instruction width.
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 0: PC loaded at reset.

- `clk`  in  1  the single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_cmd`  out  2  `00` none, `01` MREAD (`10` MWRITE is never driven).
- `mem_addr`  out  ADDR_W  read address; valid while `mem_cmd`=MREAD.
- `mem_rdata`  in  DATA_W  read data; sampled when `mem_ready`=1.
- `mem_ready`  in  1  the outstanding read completes this cycle.
- `ir_valid`  out  1  queue head holds an instruction.
- `ir_data`  out  DATA_W  head instruction; 0 when the queue is empty.
- `ir_pc`  out  ADDR_W  address of the head instruction; 0 when empty.
- `ir_take`  in  1  pop the head; ignored when `ir_valid`=0.
- `redirect`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  branch target.
- `halt`  in  1  level signal; while high, no new reads are issued.
- `fetch_pc`  out  ADDR_W  address of the next or current request.

## Operation
- **Reset** (`reset`=0, asynchronous):
  - state=IDLE, `fetch_pc`=RESET_PC, count=0, `mem_cmd`=00.
  - `ir_valid`=0, `ir_data`=0, `ir_pc`=0.
  - Queue storage is not reset.
- **States:**
  - **IDLE:** `mem_cmd`=00. Go to REQ when count<DEPTH, `halt`=0 and `redirect`=0.
  - **REQ:** `mem_cmd`=MREAD, `mem_addr`=`fetch_pc`. Address and command are held stable until `mem_ready`.
    - On `mem_ready`: push {`fetch_pc`, `mem_rdata`} and set `fetch_pc` = `fetch_pc`+1, wrapping mod 2^ADDR_W.
    - After that push, stay in REQ if the post-push count<DEPTH and `halt`=0; otherwise go to IDLE.
  - **DROP:** the request is still asserted at its old address (a request is never retracted). On `mem_ready` the data is discarded and the state goes to IDLE.
- **Redirect:**
  - Every state: count←0, `fetch_pc`←`redirect_pc`.
  - In REQ without `mem_ready`: go to DROP.
  - In REQ with `mem_ready`: the response is discarded and the state goes to IDLE.
  - In DROP: stay in DROP; `fetch_pc` takes the newest target.
  - In IDLE: stay in IDLE.
- **Pop:** `ir_take`&&`ir_valid` advances the head.
  - A push and a pop in the same cycle leave count unchanged.
  - A pop coincident with `redirect` has no effect beyond the flush.
- **Halt:** an outstanding read completes and is pushed normally. The queue is not flushed and `ir_take` is still honoured.
- **Queue ordering:** strict FIFO. The queue never overflows, because a request is only issued when count<DEPTH and only one read is outstanding.

## Timing
- `ir_valid`, `ir_data` and `ir_pc` are decoded from registers only; there is no combinational path from `ir_take`.
- `mem_cmd` and `mem_addr` come from registers only.
- **First request:** `mem_cmd`=MREAD in the cycle after the first clock edge following reset release.
- **Fetch latency:** with `mem_ready` high in the request cycle, `ir_valid`=1 after the next edge.
- **Throughput:** one instruction per cycle with zero-wait memory and a consumer popping every cycle.
- **Wait states:** N wait states give N+1 cycles per instruction.
- **Redirect:** `ir_valid`=0 from the next edge. The first new request issues one cycle after IDLE is re-entered.

## Structure
- **Shared package `cpu_pkg`:**
  - `MREAD`=2'b01, `MWRITE`=2'b10, `MNONE`=2'b00.
  - fetch state enum {IDLE, REQ, DROP}, also used by the control FSM for debug.
- **Sub-module `fetch_fifo`:**
  - Parameters DEPTH, DATA_W+ADDR_W.
  - Circular buffer with rd/wr pointers, count, synchronous `flush`, empty-gated outputs.
- **Top level:** state machine, `fetch_pc` register, and the redirect/drop logic.

## Test plan
- **Reset and zero-wait fill:** release reset with `mem_ready`=1 and no pops.
  - Reads are issued to addresses 0,1,2,3, then `mem_cmd`=00.
  - `ir_pc`=0 and `ir_data` = mem[0].
- **Wait states:** `mem_ready` delayed 2 cycles per read.
  - `mem_addr` is stable across the wait.
  - Instructions arrive every 3 cycles and `ir_pc` increments by 1.
- **Redirect mid-request:** redirect to 0x40 while the read of address 5 is waiting.
  - The state enters DROP and the mem[5] data is discarded.
  - The next request goes to 0x40, and the first valid `ir_pc` is 0x40.
- **Simultaneous events:** redirect on the same cycle as `mem_ready` and `ir_take`.
  - Queue empty on the next edge; the fetched word is not pushed.
  - `fetch_pc`=`redirect_pc`.
- **Halt:** raise `halt` while a read is outstanding.
  - That word is pushed and no further MREAD is issued.
  - Popping still drains the queue to `ir_valid`=0.
- **Wrap and async reset:** start at `redirect_pc`=0x1FF with ADDR_W=9.
  - The next fetch address is 0x000.
  - Asserting `reset` mid-REQ drops `mem_cmd` to 00 immediately, without waiting for a clock edge.
